sysarr_ctrl: RTL and testbench
==============================

# sysarr_ctrl

Sequencer that wraps the 3x3 IEEE-754 single-precision systolic array (`sysarr`). It accepts two 3x3 operand matrices as a word stream and drives the array's diagonal-skewed a/b edge inputs over three waves. It then captures the nine products from the array's c outputs at fixed cycles and returns the result matrix as a handshaked word stream. It sits directly upstream and downstream of `sysarr`: every a/b/c edge port of the array connects only to this block.

## Interface
Parameters:
- `N`, 32, word width (IEEE-754 single).
- `CAP0`, 5, run cycle in which the first result group is sampled; groups 2 and 3 follow at `CAP0+1` and `CAP0+2`.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  load word valid.
- `ld_ready`  out  1  block accepts a load word.
- `ld_data`  in  N  operand word.
- `res_valid`  out  1  result word valid.
- `res_ready`  in  1  consumer accepts the result word.
- `res_data`  out  N  result word.
- `busy`  out  1  high in RUN and DRAIN.
- `a00,a10,a20,a30,a40`  out  N  array row-edge inputs.
- `b00,b01,b02,b03,b04`  out  N  array column-edge inputs.
- `c00,c01,c02,c10,c20`  out  N  array accumulator seeds; constant 0.
- `c53,c54,c55,c35,c45`  in  N  array result outputs.

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN.
- **IDLE.** `ld_ready=1`. The first accepted word moves the FSM to LOAD.
- **LOAD.** `ld_ready=1`. A 5-bit counter indexes the words:
  - words 0–8 are A, row-major;
  - words 9–17 are B, row-major.
  - Accepting word 17 moves the FSM to RUN with run counter t=0.
- **RUN.** `ld_ready=0`. t increments every cycle, 0..CAP0+2. The a/b outputs are registered and hold:
  - t=0: a00=A00, a10=A01, a20=A02; b00=B00, b01=B10, b02=B20. All other a/b are 0.
  - t=1: a10=A10, a20=A11, a30=A12; b01=B01, b02=B11, b03=B21. All other a/b are 0.
  - t=2: a20=A20, a30=A21, a40=A22; b02=B02, b03=B12, b04=B22. All other a/b are 0.
  - t≥3, and all non-RUN states: every a/b output is 0.
- **Capture.** Registers are written on the rising edge that ends the cycle:
  - t=CAP0: D00←c55, D01←c45, D02←c35, D10←c54, D20←c53.
  - t=CAP0+1: D11←c55, D12←c45, D21←c54.
  - t=CAP0+2: D22←c55, and the FSM moves to DRAIN.
- **DRAIN.** Outputs D00..D22 row-major, index 0..8.
  - `res_data` is registered and stays stable while `res_valid=1` and `res_ready=0`.
  - The index advances on `res_valid&&res_ready`.
  - Acceptance of index 8 moves the FSM to IDLE.
- No arithmetic is done in this block. Words pass bit-exact; sign, zero, ±0 and denormals are not interpreted.

## Timing
- **Reset values.** `reset_n` low asynchronously forces:
  - state IDLE and all counters 0;
  - `ld_ready=1`, `res_valid=0`, `busy=0`, `res_data=0`;
  - all a/b/c outputs 0;
  - operand and result stores 0.
- **Reset mid-operation.** A partial load, run or drain is discarded. After release, the next accepted word is treated as A00.
- **Load throughput.** One word per cycle. Gaps with `ld_valid=0` are allowed and hold the counter.
- **Latency.** From the edge accepting word 17 to the first `res_valid=1` is CAP0+3 cycles. With the default, that is 8 cycles.
- **Drain throughput.** With `res_ready` held high, the 9 words appear on 9 consecutive cycles.
- **Back-to-back loads.** `ld_valid` asserted during RUN/DRAIN is ignored and not stalled internally. The upstream must hold the word until `ld_ready=1`.
- **Turnaround.** The cycle after index 8 is accepted, `ld_ready=1`. A word presented that cycle is accepted as A00 and the FSM goes to LOAD.
- **Simultaneous events.** `ld_valid` and `res_ready` in the same cycle cannot conflict, because LOAD and DRAIN are exclusive states.
- **`busy`.** Registered; equals (state==RUN || state==DRAIN).

## Test plan
- **Reset.** Assert `reset_n`=0 mid-RUN at t=1. Required: a00..b04 read 0 immediately, `ld_ready=1`, `res_valid=0`. A fresh 18-word load then completes normally.
- **Skew schedule.** Load A=0x00000001..0x00000009 and B=0x00000011..0x00000019. Required a/b values:
  - t=0: a00=1, a10=2, a20=3; b00=0x11, b01=0x14, b02=0x17.
  - t=1: a10=4, a20=5, a30=6; b01=0x12, b02=0x15, b03=0x18.
  - t=2: a20=7, a30=8, a40=9; b02=0x13, b03=0x16, b04=0x19.
  - t=3: all zero.
- **Capture mapping (stub array).** The stub drives c55/c45/c35/c54/c53 with a tag (t<<8)|port_id. Required:
  - D00, D01, D02, D10, D20 carry t=5;
  - D11, D12, D21 carry t=6;
  - D22 carries t=7.
- **Full-system check with the real `sysarr`.**
  - Stimulus: A rows [6.25, 2.18, 3.40], [−4.3, 1.099, 5.5], [8.67, −9.2, 0]. A00 is 0x40C80000.
  - Stimulus: B rows [0.75, 12, 3.0], [12.34, 0, −7.36], [8.12, 6.94, 2.0]. B00 is 0x3F400000.
  - Required: the drained result decodes to ≈[59.197, 98.596, 9.505], [55.0, −13.43, −9.99], [−107.03, 104.04, 93.72], within array rounding.
- **Result back-pressure.** Toggle `res_ready` 1,0,0,1,... Required: each index is delivered exactly once, `res_data` is stable while stalled, and `busy` falls the cycle after index 8 is accepted.
- **Load gaps and ignored loads.** Insert idle cycles during the load and assert `ld_valid` throughout RUN. Required: no extra word is accepted, and the result is identical to the gap-free load.

Source files
------------

// File: rtl/sysarr_ctrl.sv
// sysarr_ctrl -- sequencer around the 3x3 single-precision systolic array.
//
// Collects two 3x3 operand matrices (A then B, both row-major) as an 18-word
// stream. Over three run cycles it drives them diagonally skewed onto the
// array's row (a*) and column (b*) edge inputs. It captures the nine results
// from the array's c outputs at fixed run cycles, then returns the result
// matrix row-major as a ready/valid word stream.
//
// Ports:
//   clock, reset_n        clock (rising edge), asynchronous active-low reset
//   ld_valid/ld_ready     operand word handshake, ld_data carries the word
//   res_valid/res_ready   result word handshake, res_data carries the word
//   busy                  high while running or draining
//   a00,a10,a20,a30,a40   array row-edge inputs (registered)
//   b00,b01,b02,b03,b04   array column-edge inputs (registered)
//   c00,c01,c02,c10,c20   array accumulator seeds, tied to zero
//   c53,c54,c55,c35,c45   array result outputs, sampled at run cycles
//                         CAP0..CAP0+2
module sysarr_ctrl #(
   parameter int N    = 32,
   parameter int CAP0 = 5
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         ld_valid,
   output logic         ld_ready,
   input  logic [N-1:0] ld_data,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] res_data,
   output logic         busy,
   output logic [N-1:0] a00,
   output logic [N-1:0] a10,
   output logic [N-1:0] a20,
   output logic [N-1:0] a30,
   output logic [N-1:0] a40,
   output logic [N-1:0] b00,
   output logic [N-1:0] b01,
   output logic [N-1:0] b02,
   output logic [N-1:0] b03,
   output logic [N-1:0] b04,
   output logic [N-1:0] c00,
   output logic [N-1:0] c01,
   output logic [N-1:0] c02,
   output logic [N-1:0] c10,
   output logic [N-1:0] c20,
   input  logic [N-1:0] c53,
   input  logic [N-1:0] c54,
   input  logic [N-1:0] c55,
   input  logic [N-1:0] c35,
   input  logic [N-1:0] c45
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Run counter must reach CAP0+2.
   localparam int TW = $clog2(CAP0 + 3);
   localparam logic [TW-1:0] T_CAP0 = TW'(CAP0);
   localparam logic [TW-1:0] T_CAP1 = TW'(CAP0 + 1);
   localparam logic [TW-1:0] T_CAP2 = TW'(CAP0 + 2);

   state_t        state_r, state_nxt_s;
   logic [4:0]    cnt_r, cnt_nxt_s;      // load word index
   logic [TW-1:0] t_r, t_nxt_s;          // run cycle
   logic [3:0]    idx_r, idx_nxt_s;      // drain word index

   logic [N-1:0]  op_r [0:17];           // 0..8 = A, 9..17 = B, row-major
   logic [N-1:0]  d_r  [0:8];            // result matrix, row-major

   logic [N-1:0]  a_nxt_s [0:4];
   logic [N-1:0]  b_nxt_s [0:4];
   logic [N-1:0]  res_data_nxt_s;
   logic          ld_ready_nxt_s;
   logic          res_valid_nxt_s;
   logic          busy_nxt_s;

   logic          ld_fire_s;
   logic          res_fire_s;

   assign ld_fire_s  = ld_valid & ld_ready;
   assign res_fire_s = res_valid & res_ready;

   // The array accumulates from zero in every cell.
   assign c00 = {N{1'b0}};
   assign c01 = {N{1'b0}};
   assign c02 = {N{1'b0}};
   assign c10 = {N{1'b0}};
   assign c20 = {N{1'b0}};

   // State and counter registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 5'd0;
         t_r     <= {TW{1'b0}};
         idx_r   <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         t_r     <= t_nxt_s;
         idx_r   <= idx_nxt_s;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      t_nxt_s     = t_r;
      idx_nxt_s   = idx_r;
      case (state_r)
         ST_IDLE: begin
            // The first accepted word is A00; the counter then points at word 1.
            if (ld_fire_s) begin
               state_nxt_s = ST_LOAD;
               cnt_nxt_s   = 5'd1;
            end else begin
               cnt_nxt_s   = 5'd0;
            end
         end
         ST_LOAD: begin
            if (ld_fire_s) begin
               if (cnt_r == 5'd17) begin
                  state_nxt_s = ST_RUN;
                  cnt_nxt_s   = 5'd0;
                  t_nxt_s     = {TW{1'b0}};
               end else begin
                  cnt_nxt_s   = cnt_r + 5'd1;
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_RUN: begin
            if (t_r == T_CAP2) begin
               state_nxt_s = ST_DRAIN;
               t_nxt_s     = {TW{1'b0}};
               idx_nxt_s   = 4'd0;
            end else begin
               t_nxt_s     = t_r + {{(TW-1){1'b0}}, 1'b1};
            end
         end
         ST_DRAIN: begin
            if (res_fire_s) begin
               if (idx_r == 4'd8) begin
                  state_nxt_s = ST_IDLE;
                  idx_nxt_s   = 4'd0;
               end else begin
                  idx_nxt_s   = idx_r + 4'd1;
               end
            end else begin
               idx_nxt_s = idx_r;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 5'd0;
            t_nxt_s     = {TW{1'b0}};
            idx_nxt_s   = 4'd0;
         end
      endcase
   end

   // Next values of the registered outputs, derived from the next state.
   // Run cycle t drives row/column k of A/B at edge positions k..k+2:
   // a[k+j] = A[k][j], b[k+j] = B[j][k].
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         a_nxt_s[i] = {N{1'b0}};
         b_nxt_s[i] = {N{1'b0}};
      end
      res_data_nxt_s  = {N{1'b0}};
      ld_ready_nxt_s  = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_LOAD);
      res_valid_nxt_s = (state_nxt_s == ST_DRAIN);
      busy_nxt_s      = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
      if (state_nxt_s == ST_RUN) begin
         case (t_nxt_s)
            TW'(0): begin
               a_nxt_s[0] = op_r[0];  a_nxt_s[1] = op_r[1];  a_nxt_s[2] = op_r[2];
               b_nxt_s[0] = op_r[9];  b_nxt_s[1] = op_r[12]; b_nxt_s[2] = op_r[15];
            end
            TW'(1): begin
               a_nxt_s[1] = op_r[3];  a_nxt_s[2] = op_r[4];  a_nxt_s[3] = op_r[5];
               b_nxt_s[1] = op_r[10]; b_nxt_s[2] = op_r[13]; b_nxt_s[3] = op_r[16];
            end
            TW'(2): begin
               a_nxt_s[2] = op_r[6];  a_nxt_s[3] = op_r[7];  a_nxt_s[4] = op_r[8];
               b_nxt_s[2] = op_r[11]; b_nxt_s[3] = op_r[14]; b_nxt_s[4] = op_r[17];
            end
            default: begin
            end
         endcase
      end else if (state_nxt_s == ST_DRAIN) begin
         // D00 is already stored on the edge that enters DRAIN, D22 is
         // needed only once the index reaches 8.
         for (int i = 0; i < 9; i++) begin
            if (idx_nxt_s == 4'(i)) begin
               res_data_nxt_s = d_r[i];
            end else begin
               res_data_nxt_s = res_data_nxt_s;
            end
         end
      end else begin
         res_data_nxt_s = {N{1'b0}};
      end
   end

   // Output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ld_ready  <= 1'b1;
         res_valid <= 1'b0;
         busy      <= 1'b0;
         res_data  <= {N{1'b0}};
         a00 <= {N{1'b0}}; a10 <= {N{1'b0}}; a20 <= {N{1'b0}};
         a30 <= {N{1'b0}}; a40 <= {N{1'b0}};
         b00 <= {N{1'b0}}; b01 <= {N{1'b0}}; b02 <= {N{1'b0}};
         b03 <= {N{1'b0}}; b04 <= {N{1'b0}};
      end else begin
         ld_ready  <= ld_ready_nxt_s;
         res_valid <= res_valid_nxt_s;
         busy      <= busy_nxt_s;
         res_data  <= res_data_nxt_s;
         a00 <= a_nxt_s[0]; a10 <= a_nxt_s[1]; a20 <= a_nxt_s[2];
         a30 <= a_nxt_s[3]; a40 <= a_nxt_s[4];
         b00 <= b_nxt_s[0]; b01 <= b_nxt_s[1]; b02 <= b_nxt_s[2];
         b03 <= b_nxt_s[3]; b04 <= b_nxt_s[4];
      end
   end

   // Operand store: accepted words land at the current load index.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 18; i++) begin
            op_r[i] <= {N{1'b0}};
         end
      end else if (ld_fire_s) begin
         for (int i = 0; i < 18; i++) begin
            if (cnt_r == 5'(i)) begin
               op_r[i] <= ld_data;
            end
         end
      end
   end

   // Result capture: each anti-diagonal group leaves the array one cycle
   // after the previous one, on the same c ports.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 9; i++) begin
            d_r[i] <= {N{1'b0}};
         end
      end else if (state_r == ST_RUN) begin
         if (t_r == T_CAP0) begin
            d_r[0] <= c55;
            d_r[1] <= c45;
            d_r[2] <= c35;
            d_r[3] <= c54;
            d_r[6] <= c53;
         end
         if (t_r == T_CAP1) begin
            d_r[4] <= c55;
            d_r[5] <= c45;
            d_r[7] <= c54;
         end
         if (t_r == T_CAP2) begin
            d_r[8] <= c55;
         end
      end
   end

endmodule

// File: tb/tb_sysarr_ctrl.sv
// Self-checking bench for sysarr_ctrl. The array is replaced by a stub whose
// c outputs carry (run_cycle << 8) | port_id, so every captured result
// identifies the cycle and port it was taken from.
module tb_sysarr_ctrl;
   localparam int N    = 32;
   localparam int CAP0 = 5;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         ld_valid = 1'b0;
   logic [N-1:0] ld_data = '0;
   logic         res_ready = 1'b0;
   logic         ld_ready, res_valid, busy;
   logic [N-1:0] res_data;
   logic [N-1:0] a00, a10, a20, a30, a40, b00, b01, b02, b03, b04;
   logic [N-1:0] c00, c01, c02, c10, c20;
   logic [N-1:0] c53, c54, c55, c35, c45;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = -1000;
   logic [N-1:0] ops [0:17];
   logic [N-1:0] exp_q [$];

   typedef struct {
      int                  t;
      logic [4:0][N-1:0]   a;
      logic [4:0][N-1:0]   b;
   } skew_vec_t;
   skew_vec_t tbl [4];

   sysarr_ctrl #(.N(N), .CAP0(CAP0)) dut (
      .clock(clock), .reset_n(reset_n),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy),
      .a00(a00), .a10(a10), .a20(a20), .a30(a30), .a40(a40),
      .b00(b00), .b01(b01), .b02(b02), .b03(b03), .b04(b04),
      .c00(c00), .c01(c01), .c02(c02), .c10(c10), .c20(c20),
      .c53(c53), .c54(c54), .c55(c55), .c35(c35), .c45(c45)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   logic [7:0] tag_t;
   assign tag_t = 8'(cyc - t0);
   assign c55 = {16'h0000, tag_t, 8'h55};
   assign c45 = {16'h0000, tag_t, 8'h45};
   assign c35 = {16'h0000, tag_t, 8'h35};
   assign c54 = {16'h0000, tag_t, 8'h54};
   assign c53 = {16'h0000, tag_t, 8'h53};

   task automatic chk(input string name, input logic [5*N-1:0] act, input logic [5*N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [5*N-1:0] a_bus();
      return {a40, a30, a20, a10, a00};
   endfunction

   function automatic logic [5*N-1:0] b_bus();
      return {b04, b03, b02, b01, b00};
   endfunction

   // Sends nwords of ops[]; gap>0 inserts an idle cycle before every gap-th
   // word. With junk set, ld_valid stays high afterwards with a junk word.
   task automatic load_words(input int nwords, input int gap, input bit junk);
      @(posedge clock); #2;
      for (int i = 0; i < nwords; i++) begin
         int k;
         if (gap > 0 && i > 0 && (i % gap) == 0) begin
            ld_valid = 1'b0;
            @(posedge clock); #2;
         end
         ld_valid = 1'b1;
         ld_data  = ops[i];
         k = 0;
         @(negedge clock);
         while (!ld_ready && k < 40) begin
            @(negedge clock);
            k++;
         end
         chk("ld_ready_wait", {159'd0, ld_ready}, 160'd1);
         @(posedge clock); #2;
      end
      ld_valid = junk;
      ld_data  = 32'hDEADBEEF;
      if (nwords == 18) begin
         t0 = cyc;
         exp_q.push_back(32'h0555); exp_q.push_back(32'h0545); exp_q.push_back(32'h0535);
         exp_q.push_back(32'h0554); exp_q.push_back(32'h0655); exp_q.push_back(32'h0645);
         exp_q.push_back(32'h0553); exp_q.push_back(32'h0654); exp_q.push_back(32'h0755);
      end
   endtask

   // Applies the skew table from run cycle 0 onwards.
   task automatic check_skew();
      for (int i = 0; i < 4; i++) begin
         int k;
         k = 0;
         @(negedge clock);
         while ((cyc - t0) != tbl[i].t && k < 20) begin
            @(negedge clock);
            k++;
         end
         chk($sformatf("skew_a_t%0d", tbl[i].t), a_bus(), tbl[i].a);
         chk($sformatf("skew_b_t%0d", tbl[i].t), b_bus(), tbl[i].b);
         chk($sformatf("run_ld_ready_t%0d", tbl[i].t), {159'd0, ld_ready}, 160'd0);
         chk($sformatf("run_busy_t%0d", tbl[i].t), {159'd0, busy}, 160'd1);
         chk($sformatf("run_res_valid_t%0d", tbl[i].t), {159'd0, res_valid}, 160'd0);
      end
   endtask

   // Waits for the first result and checks its latency from the last load edge.
   task automatic wait_result();
      int k;
      k = 0;
      while (!res_valid && k < 40) begin
         @(negedge clock);
         k++;
      end
      chk("latency", 160'(cyc - t0), 160'(CAP0 + 3));
      ld_valid = 1'b0;
   endtask

   // Drains the result stream against the scoreboard. stall selects a
   // res_ready pattern of 1,0,0 repeating; otherwise ready stays high.
   task automatic drain(input bit stall);
      int  c;
      bit  done;
      c = 0;
      done = 1'b0;
      while (!done && c < 80) begin
         res_ready = stall ? ((c % 3) == 0) : 1'b1;
         if (res_valid) begin
            if (exp_q.size() == 0) begin
               chk("res_extra", {159'd0, res_valid}, 160'd0);
            end else begin
               chk("res_data", {128'd0, res_data}, {128'd0, exp_q[0]});
               if (res_ready) begin
                  void'(exp_q.pop_front());
                  if (exp_q.size() == 0) done = 1'b1;
               end
            end
         end
         @(negedge clock);
         c++;
      end
      res_ready = 1'b0;
      chk("drain_done", {159'd0, done}, 160'd1);
      chk("drain_cycles", 160'(c), stall ? 160'd25 : 160'd9);
      chk("post_busy", {159'd0, busy}, 160'd0);
      chk("post_res_valid", {159'd0, res_valid}, 160'd0);
      chk("post_ld_ready", {159'd0, ld_ready}, 160'd1);
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         tbl[i].t = i;
         tbl[i].a = '0;
         tbl[i].b = '0;
      end
      tbl[0].a[0] = 32'h1;  tbl[0].a[1] = 32'h2;  tbl[0].a[2] = 32'h3;
      tbl[0].b[0] = 32'h11; tbl[0].b[1] = 32'h14; tbl[0].b[2] = 32'h17;
      tbl[1].a[1] = 32'h4;  tbl[1].a[2] = 32'h5;  tbl[1].a[3] = 32'h6;
      tbl[1].b[1] = 32'h12; tbl[1].b[2] = 32'h15; tbl[1].b[3] = 32'h18;
      tbl[2].a[2] = 32'h7;  tbl[2].a[3] = 32'h8;  tbl[2].a[4] = 32'h9;
      tbl[2].b[2] = 32'h13; tbl[2].b[3] = 32'h16; tbl[2].b[4] = 32'h19;
      for (int i = 0; i < 9; i++) begin
         ops[i]     = 32'(i + 1);
         ops[i + 9] = 32'(i + 17);
      end

      // Reset state.
      repeat (3) @(negedge clock);
      chk("rst_ld_ready", {159'd0, ld_ready}, 160'd1);
      chk("rst_res_valid", {159'd0, res_valid}, 160'd0);
      chk("rst_busy", {159'd0, busy}, 160'd0);
      chk("rst_res_data", {128'd0, res_data}, 160'd0);
      chk("rst_a", a_bus(), 160'd0);
      chk("rst_b", b_bus(), 160'd0);
      chk("rst_c", {c00, c01, c02, c10, c20}, 160'd0);
      @(posedge clock); #2;
      reset_n = 1'b1;

      // Gap-free load, free-running drain.
      load_words(18, 0, 1'b0);
      check_skew();
      wait_result();
      drain(1'b0);

      // Gapped load, ld_valid held through RUN, stalled drain.
      load_words(18, 4, 1'b1);
      check_skew();
      wait_result();
      drain(1'b1);

      // Reset at run cycle 1.
      load_words(18, 0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      chk("pre_rst_a_t1", a_bus(), tbl[1].a);
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_a", a_bus(), 160'd0);
      chk("midrst_b", b_bus(), 160'd0);
      chk("midrst_ld_ready", {159'd0, ld_ready}, 160'd1);
      chk("midrst_res_valid", {159'd0, res_valid}, 160'd0);
      chk("midrst_busy", {159'd0, busy}, 160'd0);
      exp_q.delete();
      @(posedge clock); #2;
      reset_n = 1'b1;

      // Partial load discarded by reset; the next word must be A00.
      load_words(5, 0, 1'b0);
      #1 reset_n = 1'b0;
      @(posedge clock); #2;
      reset_n = 1'b1;
      load_words(18, 3, 1'b0);
      check_skew();
      wait_result();
      drain(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
